hazard_stall_ctrl: RTL and testbench
====================================

Name: hazard_stall_ctrl

Overview:
Hazard and sequencing controller for the 5-stage pipeline front end, with branches and jumps resolved in ID. Each cycle it decides whether to advance or hold PC and the IF/ID register, flush IF/ID, or inject a bubble into ID/EX. It tracks multi-cycle stalls with a small FSM and keeps saturating stall and flush statistics counters.

Parameters:
REG_W, 5, register-specifier width
CNT_W, 16, width of the statistics counters

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high
id_rs  in  REG_W  rs field of the instruction in ID
id_rt  in  REG_W  rt field of the instruction in ID
id_uses_rs  in  1  ID instruction reads rs
id_uses_rt  in  1  ID instruction reads rt
id_is_branch  in  1  ID holds beq/bne (compares in ID)
id_branch_taken  in  1  ID branch comparator result, valid when id_is_branch
id_jump  in  1  ID holds j/jal
ex_mem_read  in  1  EX instruction is a load
ex_reg_write  in  1  EX instruction writes a register
ex_rd  in  REG_W  destination register of the EX instruction
mem_mem_read  in  1  MEM instruction is a load
mem_rd  in  REG_W  destination register of the MEM instruction
pc_write  out  1  1 = PC updates
IF_ID_write  out  1  1 = IF/ID updates
idflush  out  1  1 = IF/ID clears on the next edge
id_ex_bubble  out  1  1 = ID/EX control fields are zeroed
stall_cycles  out  CNT_W  count of stall cycles, saturating
flush_count  out  CNT_W  count of flushes, saturating

Behaviour:
- Reset is synchronous, active-high, on clk. On reset: state=RUN, both counters=0. While reset=1, outputs are pc_write=1, IF_ID_write=1, idflush=0, id_ex_bubble=0.
- Matching: a source register matches a destination when the corresponding uses_* input is 1, the source equals the destination, and the destination is not 0. Register 0 never causes a hazard.
- Hazard classes are evaluated combinationally, in RUN only. Required stall count N:
  - load-use: ex_mem_read and EX dest matches → N=1
  - branch on EX ALU result: id_is_branch, ex_reg_write, !ex_mem_read, EX dest matches → N=1
  - branch on EX load: id_is_branch, ex_mem_read, EX dest matches → N=2
  - branch on MEM load: id_is_branch, mem_mem_read, mem_rd matches → N=1
  - When several classes apply, the largest N wins.
- FSM states: RUN and STALL2.
  - RUN with N>=1: stall this cycle (pc_write=0, IF_ID_write=0, id_ex_bubble=1, idflush=0). If N=2, go to STALL2; otherwise stay in RUN and re-evaluate next cycle.
  - STALL2: unconditional stall for one cycle, inputs ignored, then return to RUN.
  - RUN with N=0 and (id_jump, or id_is_branch with id_branch_taken): pc_write=1, IF_ID_write=1, idflush=1, id_ex_bubble=0, for exactly one cycle per ID instruction.
  - RUN with N=0 and no redirect: all enables 1, idflush=0, id_ex_bubble=0.
- Priority: stall over flush. A taken branch whose operands are not ready never flushes; it flushes in the first RUN cycle with N=0.
- idflush and id_ex_bubble are never both 1.
- Outputs are combinational from state and inputs, so the latency is 0: the control is valid in the same cycle as the hazard.
- stall_cycles increments on every cycle with pc_write=0. flush_count increments on every cycle with idflush=1. Both saturate at 2^CNT_W-1 and do not wrap.
- Reset asserted in STALL2 aborts the stall: next state is RUN.

Test Plan:
- lw $8 in EX (ex_mem_read=1, ex_rd=8); ID add reads rs=8 → one cycle with pc_write=0, IF_ID_write=0, id_ex_bubble=1. Next cycle with EX=bubble → all enables 1; stall_cycles=1.
- beq $9,$10 in ID; lw $9 in EX → exactly 2 stall cycles with the state passing through STALL2. The MEM-load match after that stalls 0 more, since the load has left MEM. stall_cycles=2.
- beq in ID, taken, no hazards → idflush=1 for one cycle, pc_write=1; flush_count=1. A j in ID gives the same result.
- ex_rd=0 with ex_mem_read=1 and id_rs=0 → no stall. id_uses_rt=0 with rt matching → no stall.
- beq taken with an EX ALU dependency → first cycle stall with idflush=0, second cycle idflush=1.
- Reset asserted while in STALL2 → next cycle RUN, counters 0. Separately, force stall_cycles near all-ones with CNT_W=4: 20 stall cycles → stall_cycles=15.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// hazard_stall_ctrl : PC / IF-ID stall, IF-ID flush and ID-EX bubble control
//                     for a 5-stage pipeline with branches resolved in ID.
// Revision: 1.0
// ============================================================================
module hazard_stall_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_is_branch,
  input  logic             id_branch_taken,
  input  logic             id_jump,
  input  logic             ex_mem_read,
  input  logic             ex_reg_write,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             mem_mem_read,
  input  logic [REG_W-1:0] mem_rd,
  output logic             pc_write,
  output logic             IF_ID_write,
  output logic             idflush,
  output logic             id_ex_bubble,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    STALL2 = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;

  logic w_ex_match;
  logic w_mem_match;
  logic w_need1;
  logic w_need2;
  logic w_stall;
  logic w_redirect;

  // Register 0 is hard-wired, so a zero destination never creates a hazard.
  always_comb begin
    w_ex_match  = (ex_rd != '0) &&
                  ((id_uses_rs && (id_rs == ex_rd)) ||
                   (id_uses_rt && (id_rt == ex_rd)));
    w_mem_match = (mem_rd != '0) &&
                  ((id_uses_rs && (id_rs == mem_rd)) ||
                   (id_uses_rt && (id_rt == mem_rd)));
  end

  always_comb begin
    w_need2    = id_is_branch && ex_mem_read && w_ex_match;
    w_need1    = (ex_mem_read && w_ex_match) ||
                 (id_is_branch && ex_reg_write && !ex_mem_read && w_ex_match) ||
                 (id_is_branch && mem_mem_read && w_mem_match);
    w_redirect = id_jump || (id_is_branch && id_branch_taken);
    w_stall    = 1'b0;
    if (!reset) begin
      w_stall = (state_q == STALL2) || w_need1 || w_need2;
    end
  end

  // A stalled redirect is held back until its operands are ready.
  always_comb begin
    pc_write     = !w_stall;
    IF_ID_write  = !w_stall;
    id_ex_bubble = w_stall;
    idflush      = !reset && (state_q == RUN) && !w_stall && w_redirect;
  end

  always_comb begin
    state_d        = state_q;
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    case (state_q)
      RUN:     if (w_need2) state_d = STALL2;
      STALL2:  state_d = RUN;
      default: state_d = RUN;
    endcase
    if (w_stall && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end
    if (idflush && (flush_count_q != '1)) begin
      flush_count_d = flush_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= RUN;
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// tb_hazard_stall_ctrl : directed scoreboard bench, 16-bit and 4-bit counters.
// Revision: 1.0
// ============================================================================
module tb_hazard_stall_ctrl;

  localparam int REG_W = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic [REG_W-1:0] id_rs, id_rt, ex_rd, mem_rd;
  logic             id_uses_rs, id_uses_rt, id_is_branch, id_branch_taken, id_jump;
  logic             ex_mem_read, ex_reg_write, mem_mem_read;

  logic        a_pw, a_ifw, a_fl, a_bb;
  logic [15:0] a_sc, a_fc;
  logic        b_pw, b_ifw, b_fl, b_bb;
  logic [3:0]  b_sc, b_fc;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.REG_W(REG_W), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_is_branch(id_is_branch), .id_branch_taken(id_branch_taken), .id_jump(id_jump),
    .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write), .ex_rd(ex_rd),
    .mem_mem_read(mem_mem_read), .mem_rd(mem_rd),
    .pc_write(a_pw), .IF_ID_write(a_ifw), .idflush(a_fl), .id_ex_bubble(a_bb),
    .stall_cycles(a_sc), .flush_count(a_fc)
  );

  hazard_stall_ctrl #(.REG_W(REG_W), .CNT_W(4)) u_dut4 (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_is_branch(id_is_branch), .id_branch_taken(id_branch_taken), .id_jump(id_jump),
    .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write), .ex_rd(ex_rd),
    .mem_mem_read(mem_mem_read), .mem_rd(mem_rd),
    .pc_write(b_pw), .IF_ID_write(b_ifw), .idflush(b_fl), .id_ex_bubble(b_bb),
    .stall_cycles(b_sc), .flush_count(b_fc)
  );

  typedef struct packed {
    logic        pw;
    logic        ifw;
    logic        fl;
    logic        bb;
    logic [15:0] sc;
    logic [15:0] fc;
    logic [3:0]  sc4;
    logic [3:0]  fc4;
  } exp_t;

  exp_t        sb_q[$];
  int          total = 0;
  int          bad   = 0;
  int          stepn = 0;
  logic [15:0] m_sc  = '0;
  logic [15:0] m_fc  = '0;
  logic [3:0]  m_sc4 = '0;
  logic [3:0]  m_fc4 = '0;

  task automatic cmp(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL s%0d.%s observed=%0h expected=%0h", stepn, tag, obs, exp);
    end
  endtask

  task automatic idle();
    id_rs = '0; id_rt = '0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    id_is_branch = 1'b0; id_branch_taken = 1'b0; id_jump = 1'b0;
    ex_mem_read = 1'b0; ex_reg_write = 1'b0; ex_rd = '0;
    mem_mem_read = 1'b0; mem_rd = '0;
  endtask

  // Inputs are already driven; push the expectation, sample mid-cycle,
  // advance the counter model for the coming edge, then move to the next cycle.
  task automatic chk(input logic pw, input logic ifw, input logic fl, input logic bb);
    exp_t e;
    e = '{pw: pw, ifw: ifw, fl: fl, bb: bb, sc: m_sc, fc: m_fc, sc4: m_sc4, fc4: m_fc4};
    sb_q.push_back(e);
    #3;
    e = sb_q.pop_front();
    cmp("pc_write",     16'(a_pw),  16'(e.pw));
    cmp("IF_ID_write",  16'(a_ifw), 16'(e.ifw));
    cmp("idflush",      16'(a_fl),  16'(e.fl));
    cmp("id_ex_bubble", 16'(a_bb),  16'(e.bb));
    cmp("stall_cycles", a_sc, e.sc);
    cmp("flush_count",  a_fc, e.fc);
    cmp("w4.pc_write",  16'(b_pw),  16'(e.pw));
    cmp("w4.idflush",   16'(b_fl),  16'(e.fl));
    cmp("w4.stall_cycles", 16'(b_sc), 16'(e.sc4));
    cmp("w4.flush_count",  16'(b_fc), 16'(e.fc4));
    if (reset) begin
      m_sc = '0; m_fc = '0; m_sc4 = '0; m_fc4 = '0;
    end else begin
      if (!e.pw) begin
        if (m_sc != 16'hFFFF) m_sc++;
        if (m_sc4 != 4'hF) m_sc4++;
      end
      if (e.fl) begin
        if (m_fc != 16'hFFFF) m_fc++;
        if (m_fc4 != 4'hF) m_fc4++;
      end
    end
    stepn++;
    @(posedge clk);
    #1;
  endtask

  task automatic load_use();
    idle();
    id_rs = 5'd8; id_uses_rs = 1'b1; ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd8;
  endtask

  task automatic beq_ex_load();
    idle();
    id_is_branch = 1'b1; id_rs = 5'd9; id_rt = 5'd10; id_uses_rs = 1'b1; id_uses_rt = 1'b1;
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd9;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    load_use();
    @(posedge clk);
    #1;
    chk(1, 1, 0, 0);                  // reset overrides a hazard
    id_jump = 1'b1;
    chk(1, 1, 0, 0);                  // reset suppresses flush
    reset = 1'b0;

    load_use();     chk(0, 0, 0, 1);
    idle();         chk(1, 1, 0, 0);

    beq_ex_load();  chk(0, 0, 0, 1);
    idle();         chk(0, 0, 0, 1);  // STALL2 stalls with idle inputs
    idle(); id_is_branch = 1'b1; id_rs = 5'd9; id_rt = 5'd10;
    id_uses_rs = 1'b1; id_uses_rt = 1'b1;
    chk(1, 1, 0, 0);

    beq_ex_load();  chk(0, 0, 0, 1);
    idle(); id_is_branch = 1'b1; id_rs = 5'd9; id_uses_rs = 1'b1;
    mem_mem_read = 1'b1; mem_rd = 5'd9;
    chk(0, 0, 0, 1);
    idle(); id_is_branch = 1'b1; id_rs = 5'd9; id_uses_rs = 1'b1;
    chk(1, 1, 0, 0);

    idle(); id_is_branch = 1'b1; id_branch_taken = 1'b1;
    chk(1, 1, 1, 0);
    idle();         chk(1, 1, 0, 0);
    idle(); id_jump = 1'b1;
    chk(1, 1, 1, 0);
    idle(); id_branch_taken = 1'b1;  // not a branch: no redirect
    chk(1, 1, 0, 0);

    idle(); ex_mem_read = 1'b1; ex_rd = 5'd0; id_uses_rs = 1'b1;
    chk(1, 1, 0, 0);
    idle(); ex_mem_read = 1'b1; ex_rd = 5'd8; id_rt = 5'd8; id_uses_rt = 1'b0;
    chk(1, 1, 0, 0);
    idle(); ex_mem_read = 1'b1; ex_rd = 5'd8; id_rt = 5'd8; id_uses_rt = 1'b1;
    chk(0, 0, 0, 1);
    idle(); ex_reg_write = 1'b1; ex_rd = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1;
    chk(1, 1, 0, 0);                  // ALU result to non-branch is forwarded

    idle(); id_is_branch = 1'b1; id_branch_taken = 1'b1; id_rs = 5'd4; id_uses_rs = 1'b1;
    ex_reg_write = 1'b1; ex_rd = 5'd4;
    chk(0, 0, 0, 1);
    ex_reg_write = 1'b0; ex_rd = 5'd0;
    chk(1, 1, 1, 0);

    idle(); id_is_branch = 1'b1; id_rt = 5'd12; id_uses_rt = 1'b1;
    mem_mem_read = 1'b1; mem_rd = 5'd12;
    chk(0, 0, 0, 1);
    idle(); id_is_branch = 1'b1; id_rt = 5'd12; id_uses_rt = 1'b1;
    mem_mem_read = 1'b0; mem_rd = 5'd12;
    chk(1, 1, 0, 0);

    beq_ex_load();  chk(0, 0, 0, 1);
    idle(); reset = 1'b1;
    chk(1, 1, 0, 0);                  // reset aborts STALL2
    reset = 1'b0;
    idle();         chk(1, 1, 0, 0);
    idle();         chk(1, 1, 0, 0);

    load_use();
    for (int i = 0; i < 20; i++) chk(0, 0, 0, 1);
    idle(); id_jump = 1'b1;
    for (int i = 0; i < 17; i++) chk(1, 1, 1, 0);
    idle();         chk(1, 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
